// File: rtl/node_io.sv
// Port-access sequencer: turns one blocking core read/write (fixed direction,
// ANY or LAST) into per-lane port strobes, honouring port occupancy.
module node_io #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_write,
  input  logic [2:0]     req_dir,
  input  logic [N-1:0]   req_data,
  output logic           done,
  output logic [N-1:0]   done_data,
  output logic           last_valid,
  output logic [1:0]     last_dir,
  output logic [3:0]     port_read,
  output logic [3:0]     port_write,
  output logic [4*N-1:0] port_out,
  input  logic [4*N-1:0] port_in,
  input  logic [3:0]     port_own_blocked,
  input  logic [3:0]     port_peer_blocked
);

  localparam int unsigned LANES    = 4;
  localparam logic [2:0]  DIR_ANY  = 3'd4;
  localparam logic [2:0]  DIR_LAST = 3'd5;

  typedef enum logic [2:0] {
    IDLE, DONE_NIL, RD_WAIT, RD_DRAIN, WR_WAIT, WR_PEND
  } state_t;

  state_t       state, state_d;
  logic         any_q;
  logic [1:0]   lane_q;
  logic [N-1:0] data_q;
  logic         seen_q, seen_d;
  logic         last_valid_q;
  logic [1:0]   last_dir_q;

  logic [1:0]   tgt;
  logic         fire;
  logic [3:0]   free_lanes;

  // ANY priority order: LEFT, RIGHT, UP, DOWN
  function automatic logic [1:0] pick(input logic [3:0] m);
    if (m[3])      return 2'd3;
    else if (m[1]) return 2'd1;
    else if (m[0]) return 2'd0;
    else           return 2'd2;
  endfunction

  assign free_lanes = ~port_own_blocked & ~port_peer_blocked;
  assign last_valid = last_valid_q & ~reset;
  assign last_dir   = reset ? 2'd0 : last_dir_q;

  always_comb begin
    state_d    = state;
    seen_d     = seen_q;
    req_ready  = 1'b0;
    done       = 1'b0;
    done_data  = '0;
    port_read  = '0;
    port_write = '0;
    port_out   = '0;
    tgt        = lane_q;
    fire       = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            if (req_dir > DIR_LAST || (req_dir == DIR_LAST && !last_valid_q))
              state_d = DONE_NIL;
            else
              state_d = req_write ? WR_WAIT : RD_WAIT;
          end
        end
        DONE_NIL: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        RD_WAIT: begin
          tgt  = any_q ? pick(port_peer_blocked) : lane_q;
          fire = any_q ? |port_peer_blocked : port_peer_blocked[lane_q];
          if (fire) begin
            port_read[tgt] = 1'b1;
            done           = 1'b1;
            for (int unsigned i = 0; i < LANES; i++)
              if (2'(i) == tgt) done_data = port_in[i*N +: N];
            state_d = RD_DRAIN;
          end
        end
        // hold off new requests until the port has retired the value just read
        RD_DRAIN: begin
          if (!port_peer_blocked[lane_q]) state_d = IDLE;
        end
        WR_WAIT: begin
          tgt  = any_q ? pick(free_lanes) : lane_q;
          fire = any_q ? |free_lanes : free_lanes[lane_q];
          if (fire) begin
            port_write[tgt] = 1'b1;
            for (int unsigned i = 0; i < LANES; i++)
              if (port_write[i]) port_out[i*N +: N] = data_q;
            seen_d  = 1'b0;
            state_d = WR_PEND;
          end
        end
        // complete once the port has shown our write and then released it
        WR_PEND: begin
          if (seen_q && !port_own_blocked[lane_q]) begin
            done    = 1'b1;
            state_d = IDLE;
          end else if (port_own_blocked[lane_q]) begin
            seen_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      any_q        <= 1'b0;
      lane_q       <= 2'd0;
      data_q       <= '0;
      seen_q       <= 1'b0;
      last_valid_q <= 1'b0;
      last_dir_q   <= 2'd0;
    end else begin
      state  <= state_d;
      seen_q <= seen_d;
      if (state == IDLE && req_valid) begin
        any_q  <= (req_dir == DIR_ANY);
        lane_q <= (req_dir == DIR_LAST) ? last_dir_q : req_dir[1:0];
        data_q <= req_data;
      end
      if (fire) begin
        lane_q <= tgt;
        if (any_q) begin
          last_valid_q <= 1'b1;
          last_dir_q   <= tgt;
        end
      end
    end
  end

endmodule

// File: tb/tb_node_io.sv
// Bench for node_io: per-lane port environment, transaction-level reference
// model, directed scenarios followed by randomized traffic.
module tb_node_io;
  localparam int unsigned N = 8;
  localparam int P_IDLE = 0, P_NIL = 1, P_RDQ = 2, P_DRAIN = 3, P_WRQ = 4, P_ACK = 5;

  logic           clk;
  logic           reset, req_valid, req_ready, req_write, done, last_valid;
  logic [2:0]     req_dir;
  logic [N-1:0]   req_data, done_data;
  logic [1:0]     last_dir;
  logic [3:0]     port_read, port_write, port_own_blocked, port_peer_blocked;
  logic [4*N-1:0] port_out, port_in;

  node_io #(.N(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_dir(req_dir), .req_data(req_data),
    .done(done), .done_data(done_data), .last_valid(last_valid),
    .last_dir(last_dir), .port_read(port_read), .port_write(port_write),
    .port_out(port_out), .port_in(port_in),
    .port_own_blocked(port_own_blocked), .port_peer_blocked(port_peer_blocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // environment: one port per lane
  bit           peer[4];
  bit           own[4];
  logic [N-1:0] pdata[4];
  int           hold_cnt[4];
  int           clr_cnt[4];
  bit           rand_arr;
  int           hold_fixed;

  // core request drive
  logic         r_reset, r_valid, r_write;
  logic [2:0]   r_dir;
  logic [N-1:0] r_data;

  // reference model
  int           ph;
  bit           m_any;
  int           m_lane;
  logic [N-1:0] m_data;
  bit           m_seen;
  bit           m_lv;
  logic [1:0]   m_ld;
  int           prio[4] = '{3, 1, 0, 2};
  bit           acc;

  // sampled DUT outputs
  logic           s_ready, s_done, s_lv;
  logic [N-1:0]   s_dd;
  logic [1:0]     s_ld;
  logic [3:0]     s_rd, s_wr;
  logic [4*N-1:0] s_out;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic [3:0]     e_rd, e_wr;
    logic [4*N-1:0] e_out;
    logic           e_done, e_ready, e_lv;
    logic [1:0]     e_ld;
    logic [N-1:0]   e_dd;
    int             lane, c;
    bit             found, usable;
    @(posedge clk);
    #1;
    reset     = r_reset;
    req_valid = r_valid;
    req_write = r_write;
    req_dir   = r_dir;
    req_data  = r_data;
    for (int p = 0; p < 4; p++) begin
      port_peer_blocked[p] = peer[p];
      port_own_blocked[p]  = own[p];
      port_in[p*N +: N]    = pdata[p];
    end
    #4;
    e_rd = '0; e_wr = '0; e_out = '0; e_done = 0; e_ready = 0;
    e_lv = 0; e_ld = '0; e_dd = '0; acc = 0;
    if (r_reset) begin
      ph = P_IDLE; m_lv = 0; m_ld = '0; m_seen = 0;
    end else begin
      e_lv = m_lv;
      e_ld = m_ld;
      case (ph)
        P_IDLE: begin
          e_ready = 1;
          if (r_valid) begin
            acc = 1;
            if (r_dir > 3'd5 || (r_dir == 3'd5 && !m_lv)) ph = P_NIL;
            else begin
              m_any  = (r_dir == 3'd4);
              m_lane = (r_dir == 3'd5) ? int'(m_ld) : int'(r_dir);
              m_data = r_data;
              ph     = r_write ? P_WRQ : P_RDQ;
            end
          end
        end
        P_NIL: begin
          e_done = 1;
          ph = P_IDLE;
        end
        P_RDQ, P_WRQ: begin
          found = 0;
          lane  = m_lane;
          for (int k = 0; k < 4; k++) begin
            c = m_any ? prio[k] : m_lane;
            usable = (ph == P_RDQ) ? peer[c] : (!peer[c] && !own[c]);
            if (!found && usable) begin found = 1; lane = c; end
          end
          if (found) begin
            if (m_any) begin m_lv = 1; m_ld = 2'(lane); end
            m_lane = lane;
            if (ph == P_RDQ) begin
              e_rd[lane] = 1; e_done = 1; e_dd = pdata[lane]; ph = P_DRAIN;
            end else begin
              e_wr[lane] = 1; e_out[lane*N +: N] = m_data; m_seen = 0; ph = P_ACK;
            end
          end
        end
        P_DRAIN: if (!peer[m_lane]) ph = P_IDLE;
        P_ACK: begin
          if (m_seen && !own[m_lane]) begin e_done = 1; ph = P_IDLE; end
          else if (own[m_lane]) m_seen = 1;
        end
        default: ph = P_IDLE;
      endcase
    end
    s_ready = req_ready; s_done = done; s_dd = done_data; s_lv = last_valid;
    s_ld = last_dir; s_rd = port_read; s_wr = port_write; s_out = port_out;
    check("req_ready",  s_ready, e_ready);
    check("done",       s_done,  e_done);
    check("done_data",  s_dd,    e_dd);
    check("last_valid", s_lv,    e_lv);
    check("last_dir",   s_ld,    e_ld);
    check("port_read",  s_rd,    e_rd);
    check("port_write", s_wr,    e_wr);
    check("port_out",   s_out,   e_out);
    // advance the port environment to the next cycle
    for (int p = 0; p < 4; p++) begin
      if (rand_arr && !peer[p] && !own[p] && clr_cnt[p] == 0 && !e_wr[p]
          && $urandom_range(7) == 0) begin
        peer[p]  = 1;
        pdata[p] = N'($urandom);
      end
      if (clr_cnt[p] > 0) begin
        clr_cnt[p]--;
        if (clr_cnt[p] == 0) peer[p] = 0;
      end
      if (hold_cnt[p] > 0) begin
        hold_cnt[p]--;
        if (hold_cnt[p] == 0) own[p] = 0;
      end
      if (e_rd[p]) clr_cnt[p] = 2;
      if (e_wr[p]) begin
        own[p]      = 1;
        hold_cnt[p] = rand_arr ? int'($urandom_range(4, 2)) : hold_fixed;
      end
    end
  endtask

  task automatic issue(input bit w, input logic [2:0] d, input logic [N-1:0] x);
    int n = 0;
    r_valid = 1; r_write = w; r_dir = d; r_data = x;
    do begin
      step();
      n++;
    end while (!acc && n < 300);
    r_valid = 0; r_write = 0; r_dir = '0; r_data = '0;
    if (!acc) check("accept_timeout", 64'(n), 64'(0));
  endtask

  task automatic settle(input int bound);
    int n = 0;
    while (ph != P_IDLE && n < bound) begin
      step();
      n++;
      if (ph == P_WRQ && n > 30)
        for (int p = 0; p < 4; p++) begin peer[p] = 0; clr_cnt[p] = 0; end
    end
    if (ph != P_IDLE) begin
      check("settle_timeout", 64'(ph), 64'(P_IDLE));
      r_reset = 1; step(); r_reset = 0;
    end
  endtask

  task automatic do_reset();
    r_reset = 1; step(); step(); r_reset = 0;
  endtask

  initial begin
    int n;
    for (int p = 0; p < 4; p++) begin
      peer[p] = 0; own[p] = 0; pdata[p] = '0; hold_cnt[p] = 0; clr_cnt[p] = 0;
    end
    rand_arr = 0; hold_fixed = 3;
    r_reset = 1; r_valid = 0; r_write = 0; r_dir = '0; r_data = '0;
    ph = P_IDLE; m_any = 0; m_lane = 0; m_data = '0; m_seen = 0; m_lv = 0; m_ld = '0;
    do_reset();
    step();
    check("t0_ready_after_reset", s_ready, 1'b1);

    // 1: write UP, far side drains after a few cycles
    issue(1'b1, 3'd0, 8'h2A);
    step();
    check("t1_strobe", s_wr, 4'b0001);
    check("t1_data", s_out[7:0], 8'h2A);
    n = 0;
    do begin step(); n++; end while (!s_done && n < 20);
    check("t1_latency", 64'(n), 64'(4));
    check("t1_done_data", s_dd, 8'h00);
    settle(50);

    // 2: read ANY picks LEFT, then read LAST
    peer[1] = 1; pdata[1] = 8'h11;
    peer[3] = 1; pdata[3] = 8'h33;
    issue(1'b0, 3'd4, 8'h00);
    step();
    check("t2_read_strobe", s_rd, 4'b1000);
    check("t2_any_data", s_dd, 8'h33);
    step();
    check("t2_last_valid", s_lv, 1'b1);
    check("t2_last_dir", s_ld, 2'd3);
    settle(50);
    peer[3] = 1; pdata[3] = 8'h44;
    issue(1'b0, 3'd5, 8'h00);
    step();
    check("t2_last_data", s_dd, 8'h44);
    settle(50);
    peer[1] = 0;

    // 3: LAST without a recorded direction completes empty
    do_reset();
    issue(1'b0, 3'd5, 8'h00);
    step();
    check("t3_done", s_done, 1'b1);
    check("t3_done_data", s_dd, 8'h00);
    check("t3_no_strobe", {s_rd, s_wr}, 8'h00);
    check("t3_last_valid", s_lv, 1'b0);
    settle(10);

    // 4: write RIGHT held off by a pending neighbour value
    peer[1] = 1; pdata[1] = 8'h99;
    issue(1'b1, 3'd1, 8'h05);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_held_off", s_wr, 4'b0000);
    end
    peer[1] = 0;
    step();
    check("t4_strobe", s_wr, 4'b0010);
    check("t4_data", s_out[15:8], 8'h05);
    settle(50);

    // 5: back-to-back DOWN reads need a fresh value
    peer[2] = 1; pdata[2] = 8'hA5;
    issue(1'b0, 3'd2, 8'h00);
    step();
    check("t5_first_read", s_rd, 4'b0100);
    for (int i = 0; i < 2; i++) begin
      step();
      check("t5_drain_ready", s_ready, 1'b0);
    end
    issue(1'b0, 3'd2, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_stale_read", s_rd, 4'b0000);
    end
    peer[2] = 1; pdata[2] = 8'h5A;
    step();
    check("t5_second_read", s_rd, 4'b0100);
    check("t5_second_data", s_dd, 8'h5A);
    settle(50);

    // 6: reset while the write is pending
    hold_fixed = 6;
    issue(1'b1, 3'd4, 8'h77);
    step();
    check("t6_any_write_lane", s_wr, 4'b1000);
    step();
    step();
    r_reset = 1;
    step();
    r_reset = 0;
    check("t6_rst_done", s_done, 1'b0);
    check("t6_rst_strobes", {s_rd, s_wr}, 8'h00);
    step();
    check("t6_ready", s_ready, 1'b1);
    check("t6_last_valid", s_lv, 1'b0);
    repeat (8) step();

    // randomized traffic
    rand_arr = 1;
    for (int t = 0; t < 300; t++) begin
      issue(1'($urandom_range(1)), 3'($urandom_range(7)), N'($urandom));
      if ($urandom_range(24) == 0) begin
        repeat ($urandom_range(3)) step();
        r_reset = 1; step(); r_reset = 0;
      end
      settle(200);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
